bs_serve_scheduler: RTL
=======================

# bs_serve_scheduler

Round-robin scheduler that shares the single packet data manager among `BSMODS` Black-Scholes compute modules. It collects per-module data requests and issues one one-hot serve grant at a time to the data manager. When the data manager returns its load strobe, it marks the served module busy until that module reports completion. It sits between the compute-module array and the data manager, and drives the manager's serve input.

## Interface
- `BSMODS`, 4: number of compute modules (≥2).
- `TIMEOUT`, 32: serve-watchdog limit in cycles; used only when the watchdog is compiled in.
- `clock` in 1: the single clock for the block; everything runs on its rising edge.
- `reset_n` in 1: reset is asynchronous and active-low.
- `mod_req` in BSMODS: level; module i wants a packet.
- `mod_done` in BSMODS: one-cycle pulse; module i finished its computation.
- `out_of_data` in 1: data manager has no packets available.
- `reg_en` in BSMODS: data manager's one-hot load strobe, one cycle.
- `serve_reg` out BSMODS: registered one-hot grant to the data manager.
- `mod_busy` out BSMODS: module i holds an unfinished packet.
- `grant_count` out 16: packets delivered since reset.
- `all_idle` out 1: `mod_busy==0` and state is IDLE.
- `timeout_err` out 1: sticky watchdog error.

## Operation
- State machine: IDLE, SERVE.
- Eligible set: `mod_req & ~mod_busy`.
- Round-robin pointer `ptr` spans 0..BSMODS-1 and resets to 0.
- **IDLE**
  - Condition: `out_of_data==0` and the eligible set is non-zero.
  - Action: search the eligible set from index `ptr` upward, wrapping past BSMODS-1 to 0.
  - The first hit g is loaded into `serve_reg` as one-hot bit g; go to SERVE.
  - Otherwise `serve_reg` stays 0.
- **SERVE**
  - `serve_reg` is held constant, even if `mod_req[g]` drops.
  - Condition: `reg_en[g]==1` in a cycle.
  - Action on the next edge:
    - set `mod_busy[g]`;
    - clear `serve_reg`;
    - `ptr` ← (g+1) mod BSMODS;
    - `grant_count`++;
    - go to IDLE.
  - `reg_en` bits other than g are ignored.
  - `out_of_data` is ignored in SERVE; a committed load always completes.
- **Busy clear**: `mod_done[i]` clears `mod_busy[i]` on the next edge, in any state.
  - Clears for several modules happen in the same cycle.
  - If set and clear coincide on the same bit, set wins.
- `grant_count` wraps from 0xFFFF to 0.
- At most one `serve_reg` bit is ever high.

## Timing
- Reset values: `serve_reg`=0, `mod_busy`=0, `grant_count`=0, `timeout_err`=0, `all_idle`=1, state IDLE, `ptr`=0.
- Request to grant: if the eligible set is non-zero at edge N in IDLE, `serve_reg` is high after edge N (1 cycle).
- Load to release: `reg_en[g]` sampled at edge M gives `serve_reg`=0 and `mod_busy[g]`=1 after edge M.
- IDLE always lasts at least 1 cycle between grants. The data manager therefore sees `serve_reg`=0 for ≥1 cycle and returns to its ready state.
- Reset mid-SERVE:
  - `serve_reg` drops asynchronously.
  - The in-flight packet is not counted.
  - No busy bit is set.
- `all_idle` is combinational from state and `mod_busy`.

## Configuration
- Macro: `BS_SERVE_WATCHDOG_EN`.
- **Defined:**
  - A cycle counter clears on entry to SERVE and increments each SERVE cycle.
  - If it reaches `TIMEOUT` with no `reg_en[g]`:
    - `serve_reg` clears;
    - `timeout_err` sets, sticky until reset;
    - `ptr` ← (g+1) mod BSMODS;
    - `mod_busy` and `grant_count` are unchanged;
    - go to IDLE.
  - If `reg_en[g]` and the timeout occur in the same cycle, the load wins.
- **Undefined:** SERVE waits indefinitely, and `timeout_err` is tied to 0.

## Test plan
- **Reset:** assert `reset_n`=0 mid-SERVE → `serve_reg`=0 immediately; `grant_count`=0, `mod_busy`=0, `all_idle`=1.
- **Round-robin order:** BSMODS=4, `mod_req`=4'b1111, `out_of_data`=0, `reg_en[g]` pulsed 6 cycles after each grant → grants in order 0001, 0010, 0100, 1000; `mod_busy`=4'b1111; `grant_count`=4; `serve_reg` low ≥1 cycle between grants.
- **Out of data:** `out_of_data`=1, `mod_req`=4'b0011 → `serve_reg` stays 0 for 20 cycles. Drop `out_of_data` → 0001 one cycle later.
- **Pointer wrap:** after granting module 1 (`ptr`=2), pulse `mod_done[0]` with `mod_req`=4'b0011 and module 1 busy → grant 0001, showing the search wraps 2→3→0.
- **Done/grant overlap:** `mod_done[2]` in the same cycle as `reg_en[1]` → `mod_busy` bit 2 clears and bit 1 sets on the same edge.
- **Watchdog (macro on, TIMEOUT=16):** grant module 0 and never pulse `reg_en` → `serve_reg`=0 and `timeout_err`=1 after 16 SERVE cycles; next grant goes to module 1; `grant_count` unchanged.

Source files
------------

// File: rtl/bs_serve_scheduler.sv
// bs_serve_scheduler: round-robin one-hot serve grant from BSMODS compute modules to one data manager.
// Define BS_SERVE_WATCHDOG_EN to abandon a serve after TIMEOUT cycles without a load strobe.
module bs_serve_scheduler #(
  parameter int BSMODS  = 4,
  parameter int TIMEOUT = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [BSMODS-1:0] mod_req,
  input  logic [BSMODS-1:0] mod_done,
  input  logic              out_of_data,
  input  logic [BSMODS-1:0] reg_en,
  output logic [BSMODS-1:0] serve_reg,
  output logic [BSMODS-1:0] mod_busy,
  output logic [15:0]       grant_count,
  output logic              all_idle,
  output logic              timeout_err
);
  localparam int PW = (BSMODS > 1) ? $clog2(BSMODS) : 1;

  typedef enum logic {IDLE, SERVE} state_t;

  state_t            r_state, w_state_nx;
  logic [PW-1:0]     r_ptr, w_ptr_nx, r_g, w_g_nx, w_off, w_hit;
  logic [PW:0]       w_sum;
  logic [BSMODS-1:0] r_serve, w_serve_nx, r_busy, w_busy_nx, w_elig, w_rot;
  logic [15:0]       r_cnt, w_cnt_nx;
  logic              w_found, w_load, w_timeout;

  assign w_elig = mod_req & ~r_busy;
  // Rotate so the pointer sits at bit 0; the lowest set bit is the next module in round-robin order
  assign w_rot  = BSMODS'({w_elig, w_elig} >> r_ptr);

  always_comb begin
    w_off   = '0;
    w_found = 1'b0;
    for (int k = BSMODS - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off   = PW'(k);
        w_found = 1'b1;
      end
    end
  end

  assign w_sum  = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_hit  = (w_sum >= (PW+1)'(BSMODS)) ? PW'(w_sum - (PW+1)'(BSMODS)) : PW'(w_sum);
  assign w_load = (r_state == SERVE) && |(reg_en & r_serve);

`ifdef BS_SERVE_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] r_wd;
  logic          r_terr;

  // The count is held at 0 outside SERVE, so it starts from 0 on every entry
  assign w_timeout   = (r_state == SERVE) && !w_load && (r_wd == WW'(TIMEOUT - 1));
  assign timeout_err = r_terr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wd   <= '0;
      r_terr <= 1'b0;
    end else begin
      r_wd   <= (r_state == SERVE && w_state_nx == SERVE) ? r_wd + 1'b1 : '0;
      r_terr <= r_terr | w_timeout;
    end
  end
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_serve_nx = r_serve;
    w_ptr_nx   = r_ptr;
    w_g_nx     = r_g;
    w_cnt_nx   = r_cnt;
    w_busy_nx  = (r_busy & ~mod_done) | (w_load ? r_serve : '0);
    if (r_state == IDLE) begin
      if (!out_of_data && w_found) begin
        w_state_nx = SERVE;
        w_serve_nx = BSMODS'(1) << w_hit;
        w_g_nx     = w_hit;
      end
    end else if (w_load || w_timeout) begin
      w_state_nx = IDLE;
      w_serve_nx = '0;
      w_ptr_nx   = (r_g == PW'(BSMODS - 1)) ? '0 : r_g + 1'b1;
      w_cnt_nx   = r_cnt + (w_load ? 16'd1 : 16'd0);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_serve <= '0;
      r_busy  <= '0;
      r_ptr   <= '0;
      r_g     <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_serve <= w_serve_nx;
      r_busy  <= w_busy_nx;
      r_ptr   <= w_ptr_nx;
      r_g     <= w_g_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  assign serve_reg   = r_serve;
  assign mod_busy    = r_busy;
  assign grant_count = r_cnt;
  assign all_idle    = (r_state == IDLE) && (r_busy == '0);
endmodule
